// File: rtl/vp_fetch_pkg.sv
// vp_fetch_pkg: shared widths, fetch FSM states and prefetch entry type for the fetch sequencer
package vp_fetch_pkg;
  localparam int INST_W = 23;
  localparam int PC_W = 16;
  localparam int OPC_MSB = 22;
  localparam int OPC_LSB = 18;
  localparam logic [4:0] HALT_OPCODE_DEFAULT = 5'b11111;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} fetch_state_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
  function automatic logic [4:0] opcode(input logic [INST_W-1:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: 2-entry prefetch FIFO whose head entry is itself the output register
module fetch_fifo2 import vp_fetch_pkg::*; (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input fetch_entry_t din,
  output fetch_entry_t head,
  output logic valid,
  output logic [1:0] count
);
  fetch_entry_t tail;
  assign valid = count != 2'd0;
  // caller only pops when non-empty and only pushes when there is room
  always_ff @(posedge clk)
    if (rst) begin
      count <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) head <= (count == 2'd2) ? tail : din;
      else if (push && count == 2'd0) head <= din;
      if (push && (pop ? count == 2'd2 : count == 2'd1)) tail <= din;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner, imem req/ack fetch, prefetch buffering, redirect squash and halt detection
// Optional perf counters perf_fetch_cnt/perf_stall_cnt when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer import vp_fetch_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [4:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input logic clk,
  input logic rst,
  input logic start,
  output logic imem_req,
  output logic [PC_W-1:0] imem_addr,
  input logic imem_ack,
  input logic [INST_W-1:0] imem_rdata,
  input logic redirect,
  input logic [PC_W-1:0] redirect_pc,
  input logic stall,
  output logic inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0] pc_out,
  output logic halted
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  fetch_state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic squash, squash_n, halt_seen, halt_seen_n;
  logic acked, take, halt_in, pop, issue;
  logic [1:0] count, count_n;
  fetch_entry_t din, head;
  fetch_fifo2 u_fifo (
    .clk(clk), .rst(rst), .push(take), .pop(pop), .flush(redirect),
    .din(din), .head(head), .valid(inst_valid), .count(count)
  );
  assign inst_out = head.inst;
  assign pc_out = head.pc;
  assign halted = state == HALT;
  always_comb begin
    din = '{pc: imem_addr, inst: imem_rdata};
    acked = imem_req && imem_ack;
    take = acked && !squash && !redirect;
    halt_in = take && opcode(imem_rdata) == HALT_OPCODE;
    pop = inst_valid && !stall && !redirect;
    count_n = redirect ? 2'd0 : count + {1'b0, take} - {1'b0, pop};
    squash_n = redirect ? (imem_req && !imem_ack) : (squash && !acked);
    halt_seen_n = redirect ? 1'b0 : (halt_seen || halt_in);
    pc_n = redirect ? redirect_pc : take ? pc + 16'd1 : pc;
    state_n = (state == IDLE) ? (start ? RUN : IDLE)
            : redirect ? RUN
            : halt_in ? DRAIN
            : (state == DRAIN && halt_seen && pop && opcode(head.inst) == HALT_OPCODE) ? HALT
            : state;
    // a squashed request must complete before the refetch goes out
    issue = state_n == RUN && (!imem_req || imem_ack) && !squash_n && count_n < 2'd2;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      squash <= 1'b0;
      halt_seen <= 1'b0;
      imem_req <= 1'b0;
      imem_addr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      squash <= squash_n;
      halt_seen <= halt_seen_n;
      imem_req <= issue || (imem_req && !imem_ack);
      if (issue) imem_addr <= pc_n;
    end
`ifdef FETCH_SEQ_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (acked && !squash && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (inst_valid && stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif
endmodule
